// File: rtl/tart_dcm_supervisor.sv
// DCM reset sequencer and clock-health supervisor: pulses the DCM reset, waits for a
// settled lock, releases the system reset and retries on lock loss or a dead clock.
module tart_dcm_supervisor #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 256,
  parameter int ACT_WINDOW    = 64,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic       toggle_i,
  output logic       dcm_rst_o,
  output logic       reset_no,
  output logic       status_no,
  output logic [3:0] retries_o,
  output logic       fault_o
);

  localparam int TMAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TMAX   = (TMAX_A > LOCK_TIMEOUT) ? TMAX_A : LOCK_TIMEOUT;
  localparam int TW     = $clog2(TMAX);
  localparam int AW     = (ACT_WINDOW > 1) ? $clog2(ACT_WINDOW) : 1;
  localparam int IW     = $clog2(ACT_WINDOW + 1);

  typedef enum logic [2:0] {
    PULSE     = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [AW-1:0] act_cnt, act_next;
  logic [IW-1:0] idle_cnt, idle_next;
  logic [3:0]    retries_next;
  logic          lock_meta, lock_sync;
  logic          tog_meta, tog_sync, tog_prev;
  logic          tog_edge, fail, entering;

  assign tog_edge = tog_sync ^ tog_prev;

  // Two-flop synchronizers; the extra toggle copy turns level changes into edge pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      tog_meta  <= 1'b0;
      tog_sync  <= 1'b0;
      tog_prev  <= 1'b0;
    end else begin
      lock_meta <= locked_i;
      lock_sync <= lock_meta;
      tog_meta  <= toggle_i;
      tog_sync  <= tog_meta;
      tog_prev  <= tog_sync;
    end
  end

  // Sequencer decisions and counter next-values
  always_comb begin
    state_next   = state;
    timer_next   = timer;
    retries_next = retries_o;
    fail         = 1'b0;
    case (state)
      PULSE: begin
        if (timer == TW'(RST_CYCLES - 1)) state_next = WAIT_LOCK;
        else                              timer_next = timer + TW'(1);
      end
      WAIT_LOCK: begin
        if (lock_sync)                             state_next = SETTLE;
        else if (timer == TW'(LOCK_TIMEOUT - 1))   fail       = 1'b1;
        else                                       timer_next = timer + TW'(1);
      end
      SETTLE: begin
        if (!lock_sync)                            fail       = 1'b1;
        else if (timer == TW'(SETTLE_CYCLES - 1))  state_next = RUN;
        else                                       timer_next = timer + TW'(1);
      end
      RUN: begin
        // lock loss and activity timeout in one cycle collapse into a single failure
        if (!lock_sync || (act_cnt == AW'(ACT_WINDOW - 1) && !tog_edge)) fail = 1'b1;
        else                                                             state_next = RUN;
      end
      FAULT:   state_next = FAULT;
      default: state_next = PULSE;
    endcase

    if (fail) begin
      if (retries_o != 4'(MAX_RETRY)) retries_next = retries_o + 4'd1;
      else                            retries_next = retries_o;
      if (retries_next == 4'(MAX_RETRY)) state_next = FAULT;
      else                               state_next = PULSE;
    end else begin
      retries_next = retries_o;
    end

    entering = (state_next != state);

    if (tog_edge || entering)                 act_next = '0;
    else if (act_cnt != AW'(ACT_WINDOW - 1))  act_next = act_cnt + AW'(1);
    else                                      act_next = act_cnt;

    if (tog_edge)                             idle_next = '0;
    else if (idle_cnt != IW'(ACT_WINDOW))     idle_next = idle_cnt + IW'(1);
    else                                      idle_next = idle_cnt;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= PULSE;
      timer     <= '0;
      act_cnt   <= '0;
      idle_cnt  <= IW'(ACT_WINDOW);
      retries_o <= 4'd0;
      fault_o   <= 1'b0;
      dcm_rst_o <= 1'b1;
      reset_no  <= 1'b0;
      status_no <= 1'b1;
    end else begin
      state     <= state_next;
      timer     <= entering ? '0 : timer_next;
      act_cnt   <= act_next;
      idle_cnt  <= idle_next;
      retries_o <= retries_next;
      fault_o   <= (state_next == FAULT);
      dcm_rst_o <= (state_next == PULSE);
      reset_no  <= (state_next == RUN);
      status_no <= (idle_next == IW'(ACT_WINDOW));
    end
  end

endmodule

// File: tb/tb_tart_dcm_supervisor.sv
// Randomized and directed bench for tart_dcm_supervisor against a timestamp-based
// reference model of the sequencing rules.
module tb_tart_dcm_supervisor;

  localparam int RC   = 4;
  localparam int LT   = 32;
  localparam int SC   = 16;
  localparam int AWIN = 8;
  localparam int MR   = 3;

  localparam int M_PULSE  = 0;
  localparam int M_WAIT   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAULT  = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       locked_i = 1'b0;
  logic       toggle_i = 1'b0;
  logic       dcm_rst_o, reset_no, status_no, fault_o;
  logic [3:0] retries_o;

  always #5 clk = ~clk;

  tart_dcm_supervisor #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC),
    .ACT_WINDOW(AWIN), .MAX_RETRY(MR)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .locked_i(locked_i), .toggle_i(toggle_i),
    .dcm_rst_o(dcm_rst_o), .reset_no(reset_no), .status_no(status_no),
    .retries_o(retries_o), .fault_o(fault_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus timestamps of phase entry and last toggle edge.
  int ph = M_PULSE;
  int fails = 0;
  int cyc = 0;
  int enter = 0;
  int last_edge = -1000;
  bit lh[2];
  bit th[3];

  task automatic model_step(input bit r, input bit lk, input bit tg);
    bit slock, e, fl;
    int age, act, nxt, start;
    if (r) begin
      ph = M_PULSE; enter = cyc + 1; last_edge = -1000; fails = 0;
      lh = '{1'b0, 1'b0}; th = '{1'b0, 1'b0, 1'b0};
    end else begin
      slock = lh[1];
      e     = th[1] ^ th[2];
      age   = cyc - enter;
      start = (enter > last_edge + 1) ? enter : last_edge + 1;
      act   = cyc - start;
      fl    = 1'b0;
      nxt   = ph;
      case (ph)
        M_PULSE:  if (age == RC - 1) nxt = M_WAIT;
        M_WAIT:   if (slock) nxt = M_SETTLE; else if (age == LT - 1) fl = 1'b1;
        M_SETTLE: if (!slock) fl = 1'b1; else if (age == SC - 1) nxt = M_RUN;
        M_RUN:    if (!slock || (act >= AWIN - 1 && !e)) fl = 1'b1;
        default:  nxt = ph;
      endcase
      if (fl) begin
        fails++;
        nxt = (fails == MR) ? M_FAULT : M_PULSE;
      end
      if (nxt != ph) enter = cyc + 1;
      ph = nxt;
      if (e) last_edge = cyc;
      lh[1] = lh[0]; lh[0] = lk;
      th[2] = th[1]; th[1] = th[0]; th[0] = tg;
    end
    cyc++;
  endtask

  task automatic compare_outputs();
    check_val("dcm_rst", dcm_rst_o, ph == M_PULSE);
    check_val("reset_n", reset_no, ph == M_RUN);
    check_val("status_n", status_no, (cyc - last_edge) > AWIN);
    check_val("retries", retries_o, fails);
    check_val("fault", fault_o, ph == M_FAULT);
  endtask

  int tg_period = 2;
  int tg_cnt = 0;
  bit tg_level = 1'b0;
  int last_flip = 0;

  task automatic tick(input bit r, input bit lk);
    if (tg_period != 0) begin
      tg_cnt++;
      if (tg_cnt >= tg_period) begin
        tg_cnt = 0;
        tg_level = ~tg_level;
        last_flip = cyc;
      end
    end
    rst_i = r; locked_i = lk; toggle_i = tg_level;
    @(posedge clk);
    model_step(r, lk, tg_level);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic reach_run();
    int g = 0;
    while (ph != M_RUN && g < 80) begin
      tick(1'b0, 1'b1);
      g++;
    end
    check_val("reach_run", reset_no, 1);
  endtask

  initial begin
    int pulse_cnt, lat, g, r0;
    bit hi_seen, stat_seen;
    bit lk_state;
    @(negedge clk);

    repeat (3) tick(1'b1, 1'b0);
    check_val("rst_dcm", dcm_rst_o, 1);
    check_val("rst_resetn", reset_no, 0);
    check_val("rst_status", status_no, 1);
    check_val("rst_retries", retries_o, 0);
    check_val("rst_fault", fault_o, 0);

    // nominal bring-up with lock at cycle 10
    pulse_cnt = (dcm_rst_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, i >= 10);
      if (dcm_rst_o === 1'b1) pulse_cnt++;
    end
    check_val("nom_pulse_len", pulse_cnt, RC);
    check_val("nom_run", reset_no, 1);
    check_val("nom_retries", retries_o, 0);

    // single-cycle lock loss in RUN
    tick(1'b0, 1'b0);
    lat = 1;
    while (reset_no === 1'b1 && lat < 10) begin
      tick(1'b0, 1'b1);
      lat++;
    end
    check_val("loss_lat_le4", lat <= 4, 1);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1);
    check_val("loss_retries", retries_o, 1);
    check_val("loss_recover", reset_no, 1);

    // dead clock with lock held
    tg_period = 0;
    stat_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 1'b1);
      if (status_no === 1'b1) stat_seen = 1'b1;
    end
    check_val("dead_status", stat_seen, 1);
    check_val("dead_retries", retries_o, 2);
    tg_period = 2;
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1);
    check_val("dead_recover", reset_no, 1);

    // simultaneous dead clock and lock drop count once
    tick(1'b1, 1'b1);
    reach_run();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    tg_period = 0;
    g = 0;
    while (cyc < last_flip + 8 && g < 20) begin
      tick(1'b0, 1'b1);
      g++;
    end
    tg_period = 2;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    check_val("simul_retries", retries_o, 1);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1);
    check_val("simul_recover", reset_no, 1);

    // glitch at SETTLE cycle 10
    tick(1'b1, 1'b1);
    g = 0;
    while (!(ph == M_SETTLE && cyc - enter == 8) && g < 40) begin
      tick(1'b0, 1'b1);
      g++;
    end
    check_val("glitch_in_settle", ph == M_SETTLE, 1);
    tick(1'b0, 1'b0);
    hi_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1);
      if (reset_no === 1'b1) hi_seen = 1'b1;
    end
    check_val("glitch_no_pulse", hi_seen, 0);
    check_val("glitch_retries", retries_o, 1);

    // lock never arrives -> FAULT after three timeouts
    tick(1'b1, 1'b0);
    for (int i = 0; i < 3 * (RC + LT) + 10; i++) tick(1'b0, 1'b0);
    check_val("tmo_fault", fault_o, 1);
    check_val("tmo_retries", retries_o, MR);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
    check_val("tmo_hold_dcm", dcm_rst_o, 0);
    check_val("tmo_hold_resetn", reset_no, 0);
    check_val("tmo_hold_fault", fault_o, 1);

    // reset out of FAULT and out of RUN
    tick(1'b1, 1'b1);
    check_val("rfault_dcm", dcm_rst_o, 1);
    check_val("rfault_retries", retries_o, 0);
    check_val("rfault_fault", fault_o, 0);
    reach_run();
    tick(1'b1, 1'b1);
    check_val("rrun_dcm", dcm_rst_o, 1);
    check_val("rrun_resetn", reset_no, 0);

    // randomized traffic
    lk_state = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) lk_state = ~lk_state;
      if ($urandom_range(0, 49) == 0) tg_period = $urandom_range(0, 10);
      r0 = ($urandom_range(0, 399) == 0) ? 1 : 0;
      tick(r0 != 0, lk_state);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
